md_iter_unit: RTL

Parametrised iterative multiply/divide unit for the EX stage, replacing the fixed 32-bit divider. It executes signed/unsigned multiply and divide on WIDTH-bit operands through a start/ready handshake and returns a 2*WIDTH-bit {hi, lo} result. It drives the EX stall request while an operation is in flight.

---
 rtl/md_iter_unit_if.sv | 30 +++
 rtl/md_iter_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/md_iter_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : md_iter_unit_if
// Purpose  : Request/response bundle between the EX stage and md_iter_unit.
//            master = requester (EX stage), slave = multiply/divide unit.
// Revision : 1.0  initial release
// ============================================================================
interface md_iter_unit_if #(
   parameter int WIDTH = 32
);
   logic                   start_i;
   logic [1:0]             op_i;
   logic [WIDTH-1:0]       opdata1_i;
   logic [WIDTH-1:0]       opdata2_i;
   logic                   annul_i;
   logic                   busy_o;
   logic                   ready_o;
   logic [2*WIDTH-1:0]     result_o;

   modport master (
      output start_i, op_i, opdata1_i, opdata2_i, annul_i,
      input  busy_o, ready_o, result_o
   );

   modport slave (
      input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
      output busy_o, ready_o, result_o
   );
endinterface
`default_nettype wire

// File: rtl/md_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_iter_unit
// Purpose  : Iterative signed/unsigned multiply/divide unit for the EX stage.
//            Radix-2 shift-add multiply, restoring divide, one bit per cycle.
//            Result is {hi, lo}: product, or {remainder, quotient}.
// Options  : MD_FAST_MUL_EN - multiplies complete in one cycle through a
//            single-cycle WIDTH x WIDTH multiplier; divides stay iterative.
// Revision : 1.0  initial release
// ============================================================================
module md_iter_unit #(
   parameter int WIDTH = 32
) (
   input  wire logic      clk,
   input  wire logic      rst,
   md_iter_unit_if.slave  md
);

   localparam int           CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] C_LAST  = CW'(WIDTH - 1);

   localparam logic [1:0]   S_IDLE   = 2'd0;
   localparam logic [1:0]   S_CALC   = 2'd1;
   localparam logic [1:0]   S_DONE   = 2'd2;

   // Architectural state
   logic [1:0]             state_q,  state_d;
   logic                   busy_q,   busy_d;
   logic                   ready_q,  ready_d;
   logic [2*WIDTH-1:0]     result_q, result_d;
   logic [CW-1:0]          cnt_q,    cnt_d;
   // acc_q: multiply = {partial product, remaining multiplier bits}
   //        divide   = low half holds dividend bits shifting into quotient
   logic [2*WIDTH-1:0]     acc_q,    acc_d;
   logic [WIDTH:0]         rem_q,    rem_d;     // partial remainder
   logic [WIDTH-1:0]       b_q,      b_d;       // multiplicand / divisor magnitude
   logic                   is_div_q, is_div_d;
   logic                   neg_res_q, neg_res_d; // negate product / quotient
   logic                   neg_rem_q, neg_rem_d; // negate remainder (dividend sign)

   // Request decode
   logic                   w_is_div, w_a_neg, w_b_neg, w_div_zero, w_accept;
   logic [WIDTH-1:0]       w_mag_a, w_mag_b;

   assign w_is_div   = md.op_i[1];
   assign w_a_neg    = md.op_i[0] & md.opdata1_i[WIDTH-1];
   assign w_b_neg    = md.op_i[0] & md.opdata2_i[WIDTH-1];
   // Negating the most negative value wraps back to itself, which read as
   // unsigned is exactly its magnitude.
   assign w_mag_a    = w_a_neg ? -md.opdata1_i : md.opdata1_i;
   assign w_mag_b    = w_b_neg ? -md.opdata2_i : md.opdata2_i;
   assign w_div_zero = w_is_div & (md.opdata2_i == '0);
   assign w_accept   = (state_q == S_IDLE) & md.start_i & ~md.annul_i;

   // One multiply step: add multiplicand to upper half if LSB set, shift right
   logic [WIDTH:0]         w_mul_sum;
   logic [2*WIDTH-1:0]     w_mul_next;
   assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

   // One restoring-divide step: shift next dividend bit in, trial subtract
   logic [WIDTH:0]         w_shift;
   logic [WIDTH+1:0]       w_trial;
   logic                   w_fits;
   logic [WIDTH:0]         w_rem_next;
   logic [WIDTH-1:0]       w_quo_next;
   assign w_shift    = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
   assign w_trial    = {1'b0, w_shift} - {2'b00, b_q};
   assign w_fits     = ~w_trial[WIDTH+1];
   assign w_rem_next = w_fits ? w_trial[WIDTH:0] : w_shift;
   assign w_quo_next = {acc_q[WIDTH-2:0], w_fits};

   // Sign fix-up applied on the final iteration
   logic [2*WIDTH-1:0]     w_prod_fix, w_calc_result;
   logic [WIDTH-1:0]       w_quo_fix, w_rem_fix;
   assign w_prod_fix    = neg_res_q ? -w_mul_next : w_mul_next;
   assign w_quo_fix     = neg_res_q ? -w_quo_next : w_quo_next;
   assign w_rem_fix     = neg_rem_q ? -w_rem_next[WIDTH-1:0] : w_rem_next[WIDTH-1:0];
   assign w_calc_result = is_div_q ? {w_rem_fix, w_quo_fix} : w_prod_fix;

`ifdef MD_FAST_MUL_EN
   logic [2*WIDTH-1:0]     w_fast_prod, w_fast_fix;
   assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
   assign w_fast_fix  = (w_a_neg ^ w_b_neg) ? -w_fast_prod : w_fast_prod;
`endif

   // Next-state and datapath update for the IDLE/CALC/DONE sequencer
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      b_d       = b_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               is_div_d  = w_is_div;
               neg_res_d = w_a_neg ^ w_b_neg;
               neg_rem_d = w_a_neg;
               b_d       = w_mag_b;
               acc_d     = {{WIDTH{1'b0}}, w_mag_a};
               rem_d     = '0;
               cnt_d     = '0;
               if (w_div_zero) begin
                  state_d  = S_DONE;
                  ready_d  = 1'b1;
                  result_d = {md.opdata1_i, {WIDTH{1'b1}}};
               end
`ifdef MD_FAST_MUL_EN
               else if (!w_is_div) begin
                  state_d  = S_DONE;
                  ready_d  = 1'b1;
                  result_d = w_fast_fix;
               end
`endif
               else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (md.annul_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               if (is_div_q) begin
                  acc_d = {acc_q[2*WIDTH-1:WIDTH], w_quo_next};
                  rem_d = w_rem_next;
               end else begin
                  acc_d = w_mul_next;
               end
               if (cnt_q == C_LAST) begin
                  state_d  = S_DONE;
                  ready_d  = 1'b1;
                  result_d = w_calc_result;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_CALC);
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         result_q  <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         b_q       <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         b_q       <= b_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign md.busy_o   = busy_q;
   assign md.ready_o  = ready_q;
   assign md.result_o = result_q;

endmodule
`default_nettype wire
